// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared VGA geometry, fetch state and pixel types for the frame-buffer scheduler
package fb_pkg;
  localparam int H_VISIBLE      = 640;
  localparam int V_VISIBLE      = 480;
  localparam int V_TOTAL        = 525;
  localparam int WORDS_PER_LINE = 160;
  localparam int WORD_W         = 8;

  typedef enum logic [1:0] {IDLE, FETCH, LAST} fetch_state_t;
  typedef logic [3:0] pix_idx_t;

  // Line that follows y in scan order, wrapping at the end of the frame.
  function automatic logic [9:0] next_line(input logic [9:0] y);
    return (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
  endfunction
endpackage

// File: rtl/fb_line_scheduler_if.sv
// rtl/fb_line_scheduler_if.sv - frame-buffer RAM port and drawing-engine write port
interface fb_line_scheduler_if #(parameter int ADDR_W = 17);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_ack;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata, wr_ack,
    input  mem_rdata, wr_req, wr_addr, wr_data
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata, wr_ack,
    output mem_rdata, wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - ping-pong line buffer, synchronous write port and asynchronous read port
module line_buffer import fb_pkg::*; #(
  parameter int H_WORDS = WORDS_PER_LINE
) (
  input  logic              Clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [WORD_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic              rbank,
  input  logic [WORD_W-1:0] raddr,
  output logic [15:0]       rdata
);
  logic [15:0] bank0 [H_WORDS];
  logic [15:0] bank1 [H_WORDS];

  always_ff @(posedge Clk) begin
    if (we) begin
      if (wbank) bank1[waddr] <= wdata;
      else       bank0[waddr] <= wdata;
    end
  end

  assign rdata = rbank ? bank1[raddr] : bank0[raddr];
endmodule

// File: rtl/fb_line_scheduler.sv
// rtl/fb_line_scheduler.sv - prefetches the next visible line into a ping-pong buffer, arbitrates
// the single-port RAM with the drawing engine and streams palette indices to the colour mapper
module fb_line_scheduler import fb_pkg::*; #(
  parameter int H_WORDS = WORDS_PER_LINE,
  parameter int ADDR_W  = 17,
  parameter int FAIR_N  = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  fb_line_scheduler_if.master         bus,
  output pix_idx_t                    pix_idx,
  output logic                        fetch_busy,
  output logic                        underrun
);
  localparam int FAIR_W = $clog2(FAIR_N + 1);

  fetch_state_t      state, state_next;
  logic [WORD_W-1:0] k, k_next;
  logic [FAIR_W-1:0] fair_cnt, fair_next;
  logic [ADDR_W-1:0] base, base_next;
  logic              bank, bank_next;
  logic [9:0]        draw_y_q;
  logic [9:0]        target;
  logic              line_start, fetch_ok;
  logic              fetch_grant, write_grant;
  logic              rd_valid, rd_bank;
  logic [WORD_W-1:0] rd_word;
  logic              visible;
  logic [15:0]       line_word;

  assign line_start = (DrawY != draw_y_q);
  assign target     = next_line(DrawY);
  assign fetch_ok   = line_start && (target < 10'(V_VISIBLE));
  assign fetch_busy = (state != IDLE);

  always_comb begin
    state_next    = state;
    k_next        = k;
    fair_next     = fair_cnt;
    base_next     = base;
    bank_next     = bank;
    fetch_grant   = 1'b0;
    write_grant   = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.wr_ack    = 1'b0;

    // Reset gates the port so nothing reaches the RAM while it is held.
    if (!Reset) begin
      if (state == FETCH && !(fair_cnt == FAIR_W'(FAIR_N) && bus.wr_req))
        fetch_grant = 1'b1;
      else if (bus.wr_req)
        write_grant = 1'b1;
    end

    if (fetch_grant) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = base + ADDR_W'(k);
    end else if (write_grant) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.wr_addr;
      bus.mem_wdata = bus.wr_data;
      bus.wr_ack    = 1'b1;
    end

    if (!bus.wr_req || write_grant) fair_next = '0;
    else if (fetch_grant)           fair_next = fair_cnt + 1'b1;

    case (state)
      FETCH: begin
        if (fetch_grant) begin
          if (k == WORD_W'(H_WORDS - 1)) state_next = LAST;
          else                           k_next     = k + 1'b1;
        end
      end
      LAST:    state_next = IDLE;
      default: ;
    endcase

    // A new line always wins: any fetch still running is abandoned.
    if (line_start) begin
      if (fetch_ok) begin
        state_next = FETCH;
        k_next     = '0;
        base_next  = (ADDR_W'(target) << 7) + (ADDR_W'(target) << 5);
        bank_next  = target[0];
      end else if (state != IDLE) begin
        state_next = IDLE;
        k_next     = '0;
      end
    end
  end

  assign visible = (DrawX < 10'(H_VISIBLE)) && (DrawY < 10'(V_VISIBLE));

  line_buffer #(.H_WORDS(H_WORDS)) u_line_buffer (
    .Clk   (Clk),
    .we    (rd_valid),
    .wbank (rd_bank),
    .waddr (rd_word),
    .wdata (bus.mem_rdata),
    .rbank (DrawY[0]),
    .raddr (visible ? DrawX[9:2] : '0),
    .rdata (line_word)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      k        <= '0;
      fair_cnt <= '0;
      base     <= '0;
      bank     <= 1'b0;
      draw_y_q <= '0;
      rd_valid <= 1'b0;
      rd_bank  <= 1'b0;
      rd_word  <= '0;
      underrun <= 1'b0;
      pix_idx  <= '0;
    end else begin
      state    <= state_next;
      k        <= k_next;
      fair_cnt <= fair_next;
      base     <= base_next;
      bank     <= bank_next;
      draw_y_q <= DrawY;
      rd_valid <= fetch_grant;
      rd_bank  <= bank;
      rd_word  <= k;
      if (line_start && state != IDLE) underrun <= 1'b1;
      pix_idx  <= visible ? line_word[{DrawX[1:0], 2'b00} +: 4] : 4'h0;
    end
  end
endmodule

// File: tb/tb_fb_line_scheduler.sv
// tb/tb_fb_line_scheduler.sv - directed self-checking bench for fb_line_scheduler
module tb_fb_line_scheduler;
  import fb_pkg::*;
  localparam int ADDR_W = 17;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  pix_idx_t   pix_idx;
  logic       fetch_busy;
  logic       underrun;
  int         checks = 0;
  int         errors = 0;

  fb_line_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  fb_line_scheduler #(.H_WORDS(160), .ADDR_W(ADDR_W), .FAIR_N(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .bus        (bus),
    .pix_idx    (pix_idx),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] pat(input logic [ADDR_W-1:0] a);
    return (a == 17'd1760) ? 16'h3210 : (a[15:0] ^ 16'hA5A5);
  endfunction

  always @(posedge Clk) begin
    if (Reset) bus.mem_rdata <= '0;
    else if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= pat(bus.mem_addr);
  end

  task automatic test_reset();
    bus.wr_req = 1'b1; bus.wr_addr = 17'h00123; bus.wr_data = 16'h5555;
    repeat (3) @(negedge Clk);
    checks++; if (bus.mem_en !== 1'b0 || bus.wr_ack !== 1'b0) begin errors++; $display("FAIL reset_port: en=%b ack=%b expected 0 0", bus.mem_en, bus.wr_ack); end
    checks++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_bus: addr=%0h wdata=%0h we=%b expected 0", bus.mem_addr, bus.mem_wdata, bus.mem_we); end
    checks++; if (fetch_busy !== 1'b0 || underrun !== 1'b0 || pix_idx !== 4'h0) begin errors++; $display("FAIL reset_out: busy=%b underrun=%b pix=%0h expected 0 0 0", fetch_busy, underrun, pix_idx); end
    bus.wr_req = 1'b0;
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checks++; if (bus.mem_en !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_idle[%0d]: en=%b busy=%b expected 0 0", i, bus.mem_en, fetch_busy); end
    end
  endtask

  task automatic test_fetch();
    DrawY = 10'd9;
    repeat (200) @(negedge Clk);
    DrawY = 10'd10;
    for (int i = 0; i < 160; i++) begin
      @(negedge Clk);
      checks++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 17'(1760 + i) || fetch_busy !== 1'b1) begin
        errors++; $display("FAIL fetch_read[%0d]: en=%b we=%b addr=%0d busy=%b expected read at %0d", i, bus.mem_en, bus.mem_we, bus.mem_addr, fetch_busy, 1760 + i);
      end
    end
    @(negedge Clk);
    checks++; if (fetch_busy !== 1'b1 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL fetch_last: busy=%b en=%b expected 1 0", fetch_busy, bus.mem_en); end
    @(negedge Clk);
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL fetch_done: busy=%b expected 0", fetch_busy); end
  endtask

  task automatic test_display();
    int       xs [9]  = '{0, 1, 2, 3, 4, 7, 639, 640, 700};
    pix_idx_t exp [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hA, 4'h0, 4'h0};
    DrawY = 10'd11;
    for (int i = 0; i < 9; i++) begin
      DrawX = 10'(xs[i]);
      @(negedge Clk);
      checks++; if (pix_idx !== exp[i]) begin errors++; $display("FAIL display_x%0d: pix=%0h expected %0h", xs[i], pix_idx, exp[i]); end
    end
    DrawX = '0;
    repeat (170) @(negedge Clk);
  endtask

  task automatic test_fair();
    int rd = 0;
    int grp = 0;
    int acks = 0;
    logic exp_wr;
    logic exp_busy;
    logic [ADDR_W-1:0] exp_addr;
    DrawY = 10'd100;
    bus.wr_req = 1'b1; bus.wr_addr = 17'h1ABCD; bus.wr_data = 16'hBEEF;
    #1;
    for (int c = 0; c < 182; c++) begin
      if (c > 0) @(negedge Clk);
      exp_addr = '0;
      if (c == 0 || c >= 181 || grp == 8 || rd == 160) begin
        exp_wr = 1'b1; grp = 0;
      end else begin
        exp_wr = 1'b0; exp_addr = 17'(16160 + rd); rd++; grp++;
      end
      exp_busy = (c >= 1 && c <= 180);
      if (c >= 1 && c <= 180 && bus.wr_ack === 1'b1) acks++;
      checks++;
      if (exp_wr) begin
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.wr_ack !== 1'b1 || bus.mem_addr !== 17'h1ABCD || bus.mem_wdata !== 16'hBEEF) begin
          errors++; $display("FAIL fair_write[%0d]: en=%b we=%b ack=%b addr=%0h wdata=%0h expected write 1abcd/beef", c, bus.mem_en, bus.mem_we, bus.wr_ack, bus.mem_addr, bus.mem_wdata);
        end
      end else begin
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.wr_ack !== 1'b0 || bus.mem_addr !== exp_addr) begin
          errors++; $display("FAIL fair_read[%0d]: en=%b we=%b ack=%b addr=%0d expected read at %0d", c, bus.mem_en, bus.mem_we, bus.wr_ack, bus.mem_addr, exp_addr);
        end
      end
      checks++; if (fetch_busy !== exp_busy) begin errors++; $display("FAIL fair_busy[%0d]: busy=%b expected %b", c, fetch_busy, exp_busy); end
    end
    checks++; if (acks !== 20) begin errors++; $display("FAIL fair_ack_count: acks=%0d expected 20", acks); end
    bus.wr_req = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic test_wrap();
    DrawY = 10'd523;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      checks++; if (bus.mem_en !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL wrap_523[%0d]: en=%b busy=%b expected 0 0", i, bus.mem_en, fetch_busy); end
    end
    DrawY = 10'd524;
    for (int i = 0; i < 160; i++) begin
      @(negedge Clk);
      checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 17'(i)) begin errors++; $display("FAIL wrap_read[%0d]: en=%b we=%b addr=%0d expected read at %0d", i, bus.mem_en, bus.mem_we, bus.mem_addr, i); end
    end
    repeat (3) @(negedge Clk);
    DrawY = 10'd0;
    @(negedge Clk);
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 17'd160) begin errors++; $display("FAIL wrap_line1: en=%b addr=%0d expected read at 160", bus.mem_en, bus.mem_addr); end
    repeat (170) @(negedge Clk);
    DrawX = 10'd0; @(negedge Clk);
    checks++; if (pix_idx !== 4'h5) begin errors++; $display("FAIL wrap_pix0: pix=%0h expected 5", pix_idx); end
    DrawX = 10'd1; @(negedge Clk);
    checks++; if (pix_idx !== 4'hA) begin errors++; $display("FAIL wrap_pix1: pix=%0h expected a", pix_idx); end
    DrawX = 10'd4; @(negedge Clk);
    checks++; if (pix_idx !== 4'h4) begin errors++; $display("FAIL wrap_pix4: pix=%0h expected 4", pix_idx); end
    DrawX = 10'd0;
  endtask

  task automatic test_no_fetch();
    DrawY = 10'd478;
    @(negedge Clk);
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 17'd76640) begin errors++; $display("FAIL line479_fetch: en=%b addr=%0d expected read at 76640", bus.mem_en, bus.mem_addr); end
    repeat (170) @(negedge Clk);
    DrawY = 10'd479;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      checks++; if (bus.mem_en !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL nofetch_479[%0d]: en=%b busy=%b expected 0 0", i, bus.mem_en, fetch_busy); end
    end
    DrawY = 10'd480; DrawX = 10'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      checks++; if (bus.mem_en !== 1'b0 || fetch_busy !== 1'b0 || pix_idx !== 4'h0) begin errors++; $display("FAIL nofetch_480[%0d]: en=%b busy=%b pix=%0h expected 0 0 0", i, bus.mem_en, fetch_busy, pix_idx); end
    end
    DrawX = 10'd0;
  endtask

  task automatic test_underrun();
    DrawY = 10'd200;
    repeat (100) @(negedge Clk);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_before: underrun=%b expected 0", underrun); end
    DrawY = 10'd201;
    #1;
    checks++; if (bus.mem_addr !== 17'(32160 + 99)) begin errors++; $display("FAIL underrun_inflight: addr=%0d expected %0d", bus.mem_addr, 32160 + 99); end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 17'(32320 + i) || underrun !== 1'b1) begin errors++; $display("FAIL underrun_restart[%0d]: en=%b addr=%0d underrun=%b expected read at %0d underrun 1", i, bus.mem_en, bus.mem_addr, underrun, 32320 + i); end
    end
    repeat (170) @(negedge Clk);
    checks++; if (underrun !== 1'b1 || fetch_busy !== 1'b0) begin errors++; $display("FAIL underrun_sticky: underrun=%b busy=%b expected 1 0", underrun, fetch_busy); end
  endtask

  task automatic test_reset_mid();
    DrawY = 10'd300;
    repeat (20) @(negedge Clk);
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL midreset_pre: busy=%b expected 1", fetch_busy); end
    Reset = 1'b1;
    #1;
    checks++; if (bus.mem_en !== 1'b0 || bus.wr_ack !== 1'b0 || bus.mem_addr !== '0) begin errors++; $display("FAIL midreset_port: en=%b ack=%b addr=%0d expected 0", bus.mem_en, bus.wr_ack, bus.mem_addr); end
    checks++; if (fetch_busy !== 1'b0 || underrun !== 1'b0 || pix_idx !== 4'h0) begin errors++; $display("FAIL midreset_out: busy=%b underrun=%b pix=%0h expected 0 0 0", fetch_busy, underrun, pix_idx); end
    DrawY = 10'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      checks++; if (bus.mem_en !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL midreset_idle[%0d]: en=%b busy=%b expected 0 0", i, bus.mem_en, fetch_busy); end
    end
    DrawY = 10'd5;
    @(negedge Clk);
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 17'd960) begin errors++; $display("FAIL midreset_refetch: en=%b addr=%0d expected read at 960", bus.mem_en, bus.mem_addr); end
    repeat (170) @(negedge Clk);
  endtask

  initial begin
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    test_reset();
    test_fetch();
    test_display();
    test_fair();
    test_wrap();
    test_no_fetch();
    test_underrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_line_scheduler.md
# fb_line_scheduler

Frame-buffer scheduler between the single-port frame-buffer RAM, the VGA timing controller and the drawing engine. During each scanline it prefetches the next visible line (160 words of 4 packed 4-bit palette indices) into a ping-pong line buffer. It serves drawing-engine writes in all remaining RAM cycles, with a fairness guard, and streams the current line's palette index to the colour mapper.

## Interface
Parameters:
- H_WORDS, 160: RAM words per visible line (640 px / 4).
- ADDR_W, 17: RAM word-address width.
- FAIR_N, 8: maximum consecutive fetch grants while a write is pending.

Ports:
- Clk  in  1: system clock. The VGA pixel clock is Clk/2, so DrawX/DrawY change on Clk edges.
- Reset  in  1: asynchronous, active-high.
- DrawX, DrawY  in  10 each: from the VGA controller.
- mem_en  out  1: RAM access this cycle.
- mem_we  out  1: write strobe; 0 means read.
- mem_addr  out  ADDR_W: RAM word address.
- mem_wdata  out  16: write data.
- mem_rdata  in  16: read data, valid the Clk after a read.
- wr_req  in  1: write request.
- wr_addr  in  ADDR_W: write address, held stable until acknowledged.
- wr_data  in  16: write data, held stable until acknowledged.
- wr_ack  out  1: pulse in the cycle the write is issued.
- pix_idx  out  4: palette index for the current pixel; registered.
- fetch_busy  out  1: prefetch in progress.
- underrun  out  1: sticky; cleared only by Reset.

## Operation
Line-start detection:
- DrawY_q registers DrawY each Clk.
- line_start = (DrawY != DrawY_q). This covers every line, including the 524→0 wrap.

Fetch target:
- On line_start with new DrawY = y, target t = (y == 524) ? 0 : y + 1.
- A fetch starts only if t < 480.
- Base address = t*160, computed as (t<<7)+(t<<5).
- Fetch bank = t[0].

FSM:
- IDLE → FETCH on a qualifying line_start. Clear k := 0.
- FETCH: each granted cycle issues a read at base + k, then k++. After the grant with k = H_WORDS-1, go to LAST.
- LAST: capture the final rdata, then go to IDLE.
- fetch_busy = (state != IDLE).

Return pipeline:
- Read data granted in cycle c is written into line-buffer bank t[0], word k, in cycle c+1.

Arbitration:
- In IDLE and LAST, the writer is granted whenever wr_req is high.
- In FETCH, the fetch wins, except when fair_cnt == FAIR_N with wr_req high. That cycle goes to the writer, fair_cnt := 0, and k does not advance.
- fair_cnt increments on each fetch grant while wr_req is high, and resets to 0 when wr_req is low.

Memory-port drive:
- mem_* and wr_ack are combinational from the state and the writer inputs.
- Writer grant: mem_en = 1, mem_we = 1, wr_ack = 1.

Display read:
- Read bank DrawY[0], word DrawX[9:2], nibble DrawX[1:0]. Pixel 4k+j is in bits [4j+3:4j].
- pix_idx is registered and forced to 0 when DrawX ≥ 640 or DrawY ≥ 480.

Boundary cases:
- line_start while fetch_busy: set underrun, discard the old fetch, restart for the new target. The in-flight rdata still lands at the old bank/word.
- line_start and wr_req in the same cycle while IDLE: the writer is granted that cycle and FETCH begins next cycle.
- Worst-case fetch length is 180 Clk, against a 1600-Clk line period.
- Line 0 of the first frame after Reset is not prefetched, because no line_start is seen. Its content is don't-care.

## Timing
- Reset values: state IDLE, k = 0, fair_cnt = 0, DrawY_q = 0. Outputs pix_idx = 0, underrun = 0, fetch_busy = 0, and all mem_* = 0, wr_ack = 0. The line buffer is not reset.
- Reset asserted mid-fetch aborts immediately; no further RAM accesses are issued.
- Fetch begins 1 Clk after line_start.
- pix_idx latency: 1 Clk after a DrawX/DrawY change.
- The line buffer has a combinational read port and synchronous writes. Read and write banks always differ within a visible line.

## Structure
- Shared package fb_pkg holds:
  - VGA geometry constants (640, 480, 525, H_WORDS).
  - typedef enum {IDLE, FETCH, LAST} fetch_state_t.
  - typedef logic [3:0] pix_idx_t.
- Sub-module line_buffer: 2 banks × H_WORDS × 16 bits, one write port and one asynchronous read port.

## Test plan
- DrawY 9→10 with no writer → 160 consecutive reads at addresses 1760..1919, then fetch_busy falls 161 Clk after start. Bank 1 holds the data. Display of line 11 shows word 0x3210 as pix_idx 0,1,2,3.
- wr_req held high through a fetch → after every 8 reads, one write with a wr_ack pulse. Total fetch time 180 Clk. mem_wdata and mem_addr match wr_data/wr_addr.
- DrawY 524→0 → fetch of line 0 at addresses 0..159 into bank 0. DrawY 479→480 → no fetch.
- Force line_start 100 Clk into a fetch → underrun = 1 and stays 1. A new fetch restarts at k = 0 for the new target.
- Reset asserted during FETCH → mem_en = 0 next edge, all outputs 0. No fetch starts until the next DrawY change.
- DrawX ≥ 640 on a visible line → pix_idx = 0.
